// File: rtl/logic_unit_ctrl.sv
// logic_unit_ctrl
// Sequential initiator for an external combinational 8-bit logic unit
// (AND/OR/XOR/NOT). Accepts a command, drives the unit, waits a fixed
// settle time, captures the result, cross-checks it against a locally
// computed value, and returns it on a valid/ready response port.
module logic_unit_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2,   // legal 1..15 (4-bit settle counter)
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // command port
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_x,
  input  logic [WIDTH-1:0]     cmd_y,
  input  logic [1:0]           cmd_op,
  // logic unit interface
  output logic [WIDTH-1:0]     lu_x,
  output logic [WIDTH-1:0]     lu_y,
  output logic                 lu_sel0,
  output logic                 lu_sel1,
  input  logic [WIDTH-1:0]     lu_f,
  // response port
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_f,
  output logic [1:0]           rsp_op,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  // status
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Counter loads SETTLE_CYCLES-1 so the capture edge lands exactly
  // SETTLE_CYCLES edges after the accept edge.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t                 r_state;
  logic [3:0]             r_settle_cnt;
  logic [WIDTH-1:0]       r_lu_x;
  logic [WIDTH-1:0]       r_lu_y;
  logic                   r_sel0;
  logic                   r_sel1;
  logic [WIDTH-1:0]       r_rsp_f;
  logic [1:0]             r_rsp_op;
  logic                   r_rsp_zero;
  logic                   r_rsp_err;
  logic [CNT_WIDTH-1:0]   r_op_count;

  logic                   w_cmd_fire;
  logic                   w_rsp_fire;
  logic [WIDTH-1:0]       w_expected;

  // Handshakes; cmd_ready depends on state only, never on cmd_valid.
  assign cmd_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign w_cmd_fire = cmd_valid  & cmd_ready;
  assign w_rsp_fire = rsp_valid  & rsp_ready;

  // Reference result, computed from the operands actually driven to the unit.
  always_comb begin
    w_expected = '0;
    case ({r_sel1, r_sel0})
      2'b00:   w_expected = r_lu_x & r_lu_y;
      2'b01:   w_expected = r_lu_x | r_lu_y;
      2'b10:   w_expected = r_lu_x ^ r_lu_y;
      default: w_expected = ~r_lu_x;
    endcase
  end

  // Control FSM: IDLE -> SETTLE -> RESP -> IDLE, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_lu_x       <= '0;
      r_lu_y       <= '0;
      r_sel0       <= 1'b0;
      r_sel1       <= 1'b0;
      r_rsp_f      <= '0;
      r_rsp_op     <= 2'b00;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_lu_x       <= cmd_x;
            r_lu_y       <= cmd_y;
            r_sel0       <= cmd_op[0];
            r_sel1       <= cmd_op[1];
            r_settle_cnt <= SETTLE_LOAD;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == 4'd0) begin
            r_rsp_f    <= lu_f;
            r_rsp_op   <= {r_sel1, r_sel0};
            r_rsp_zero <= ~|lu_f;
            r_rsp_err  <= (lu_f != w_expected);
            r_state    <= S_RESP;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        S_RESP: begin
          // rsp_* hold until the consumer takes them; lu_* keep last value.
          if (w_rsp_fire) begin
            r_op_count <= r_op_count + CNT_WIDTH'(1);
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lu_x     = r_lu_x;
  assign lu_y     = r_lu_y;
  assign lu_sel0  = r_sel0;
  assign lu_sel1  = r_sel1;
  assign rsp_f    = r_rsp_f;
  assign rsp_op   = r_rsp_op;
  assign rsp_zero = r_rsp_zero;
  assign rsp_err  = r_rsp_err;
  assign op_count = r_op_count;

endmodule
